// File: rtl/correlator_lag_feeder.sv
// Buffers one block of (a,b) sample pairs, then streams a[n], b[n+k] operand pairs
// for every lag k = 0..MAX_LAG with lag framing markers for a free-running MAC.
module correlator_lag_feeder #(
  parameter int DATA_W    = 32,
  parameter int N_SAMPLES = 16,
  parameter int MAX_LAG   = 7
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              in_a,
  input  logic [DATA_W-1:0]              in_b,
  output logic [DATA_W-1:0]              a_out,
  output logic [DATA_W-1:0]              b_out,
  output logic                           pair_valid,
  output logic                           lag_first,
  output logic                           lag_last,
  output logic [$clog2(MAX_LAG+1)-1:0]   lag_idx,
  output logic                           busy,
  output logic                           done
);

  localparam int CW = $clog2(N_SAMPLES);
  localparam int KW = $clog2(MAX_LAG + 1);
  localparam logic [CW-1:0] LAST_N = CW'(N_SAMPLES - 1);
  localparam logic [KW-1:0] LAST_K = KW'(MAX_LAG);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state;
  logic [DATA_W-1:0] a_buf [N_SAMPLES];
  logic [DATA_W-1:0] b_buf [N_SAMPLES];
  logic [CW-1:0]     wr_ptr;
  logic [CW-1:0]     n_r;
  logic [KW-1:0]     k_r;

  logic          load_fire;
  logic          load_last;
  logic          final_out;
  logic          issue;
  logic [CW-1:0] n_end;
  logic [CW-1:0] b_idx;
  logic          n_wrap;

  assign in_ready = (state == S_LOAD);
  assign busy     = (state == S_LOAD) || (state == S_RUN);

  always_comb begin
    load_fire = (state == S_LOAD) && in_valid;
    load_last = load_fire && (wr_ptr == LAST_N);
    final_out = pair_valid && lag_last && (lag_idx == LAST_K);
    n_end     = LAST_N - CW'(k_r);
    n_wrap    = (n_r == n_end);
    b_idx     = n_r + CW'(k_r);
    // (n_r,k_r) always names the next pair; the last load handshake issues (0,0)
    // through the same path as RUN, so the first pair lands one cycle later.
    issue     = load_last || ((state == S_RUN) && !final_out);
  end

  // Sample storage needs no reset: contents are rewritten before every RUN.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      a_buf[wr_ptr] <= in_a;
      b_buf[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      n_r        <= '0;
      k_r        <= '0;
      a_out      <= '0;
      b_out      <= '0;
      pair_valid <= 1'b0;
      lag_first  <= 1'b0;
      lag_last   <= 1'b0;
      lag_idx    <= '0;
      done       <= 1'b0;
    end else begin
      a_out      <= '0;
      b_out      <= '0;
      pair_valid <= 1'b0;
      lag_first  <= 1'b0;
      lag_last   <= 1'b0;
      lag_idx    <= '0;
      done       <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_LOAD;
            wr_ptr <= '0;
            n_r    <= '0;
            k_r    <= '0;
          end
        end
        S_LOAD: begin
          if (load_fire) begin
            wr_ptr <= wr_ptr + 1'b1;
          end
          if (load_last) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (final_out) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (issue) begin
        pair_valid <= 1'b1;
        a_out      <= a_buf[n_r];
        b_out      <= b_buf[b_idx];
        lag_first  <= (n_r == '0);
        lag_last   <= n_wrap;
        lag_idx    <= k_r;
        if (n_wrap) begin
          n_r <= '0;
          k_r <= k_r + 1'b1;
        end else begin
          n_r <= n_r + 1'b1;
        end
      end
    end
  end

endmodule
